axis_length_fit: RTL and testbench
==================================

# axis_length_fit

Parametrised AXI-Stream packet length normaliser placed upstream of fixed-frame consumers (MAC framers, DMA descriptors). It pads short packets up to a programmed beat count with `fill_data` beats, and optionally truncates long packets to that count, discarding excess input beats. One registered output stage gives full throughput and a one-cycle pass-through latency. Per-packet pad and truncate status pulses support error counters.

## Interface
Parameters:
- `DSIZE`, 32: data width in bits; multiple of 8.
- `USIZE`, 1: tuser width.
- `LSIZE`, 16: width of the length field and beat counter.
- `TRUNCATE`, 1: 1 = cut packets longer than `length`; 0 = pass long packets unchanged.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fill_data` in DSIZE: data for pad beats.
- `length` in LSIZE: target beats per packet; 0 = bypass; sampled on the first accepted beat of each packet.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tdata` in DSIZE, `s_axis_tkeep` in DSIZE/8, `s_axis_tuser` in USIZE, `s_axis_tlast` in 1: input stream.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out DSIZE, `m_axis_tkeep` out DSIZE/8, `m_axis_tuser` out USIZE, `m_axis_tlast` out 1: output stream.
- `pkt_padded` out 1: one-cycle pulse when a padded packet's last beat is accepted downstream.
- `pkt_truncated` out 1: one-cycle pulse when the last discarded input beat of a truncated packet is accepted.

## Operation
- Output register (`m_axis_*`) loads when `!m_axis_tvalid || m_axis_tready` (slot free).
- `len_l` (LSIZE) holds `length`, latched when `cnt==0` and an input beat is accepted. `length` changes mid-packet are ignored.
- `cnt` (LSIZE) counts beats emitted in the current output packet. It saturates at all-ones, clears on an emitted tlast, and is never incremented by dropped beats.
- FSM states: PASS, PAD, DROP.
- PASS: `s_axis_tready` = slot free. Each accepted beat copies tdata, tkeep and tuser to the output. The output tlast and next state are decided by the first matching rule:
  - `len_l==0` (taking `length` when `cnt==0`): tlast = `s_axis_tlast`; stay in PASS.
  - `s_axis_tlast` and `cnt < len_l-1`: tlast = 0; go to PAD.
  - `cnt == len_l-1` and `s_axis_tlast`: tlast = 1; stay in PASS (exact length).
  - `cnt == len_l-1`, `!s_axis_tlast`, `TRUNCATE=1`: tlast = 1; go to DROP.
  - otherwise: tlast = `s_axis_tlast` (with `TRUNCATE=0`, long packets pass unchanged).
- PAD: `s_axis_tready`=0. On each free slot, emit `fill_data`, tkeep all ones, tuser 0. tlast = (`cnt==len_l-1`). Return to PASS when that tlast beat loads. `pkt_padded` pulses when it is accepted downstream.
- DROP: `s_axis_tready`=1 and no output is loaded. On an accepted input beat with tlast: pulse `pkt_truncated` and go to PASS.
- tvalid deasserts after acceptance unless a new beat loads in the same cycle.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser`, `m_axis_tlast` = 0; `s_axis_tready`=0 while `rst` is asserted; pulses = 0; FSM = PASS; `cnt`, `len_l` = 0.
- Reset mid-packet: the packet in flight is abandoned. The first beat after reset is treated as a packet start.
- Latency is 1 cycle from input acceptance to `m_axis_tvalid`. Throughput is 1 beat/cycle in PASS and PAD with `m_axis_tready` held high.
- Transitions:
  - PASS→PAD happens on the short tlast beat. The first fill beat loads the next cycle, with no bubble when downstream is ready.
  - PAD→PASS happens on the last fill load. A new input beat may be accepted in the same cycle the last fill beat is accepted.
- Output holds stable while `m_axis_tvalid && !m_axis_tready`; `s_axis_tready` drops in PASS in that case.
- DROP ignores `m_axis_tready`; draining continues while the truncated tlast beat sits stalled in the output register.
- `len_l==1`: every packet is emitted as one beat. A one-beat input packet passes exactly; longer packets are truncated to one beat.

## Test plan
- `length`=8, 3-beat packet D0..D2 with fill=0xAA55AA55 → 8 output beats D0,D1,D2 then 5×fill; tlast only on beat 7; fill tuser=0, tkeep=0xF; `pkt_padded` pulses once.
- `length`=4, `TRUNCATE=1`, 7-beat packet → 4 beats, tlast on D3; D4..D6 accepted with no output; `pkt_truncated` pulses on D6.
- `TRUNCATE=0`, `length`=4, 7-beat packet → 7 beats unchanged; tlast on D6; no status pulses.
- `length`=0 and `length`=5 with a 5-beat packet → both bypass exactly; no pulses; back-to-back packets show no bubble.
- Random `m_axis_tready` (50%) on a padded packet → data stable under stall; beat count still 8; `length` changed mid-packet has no effect.
- `rst` asserted for 2 cycles during PAD → all outputs 0 immediately; a subsequent 2-beat packet with `length`=3 yields D0,D1,fill with tlast on beat 2.

Source files
------------

// File: rtl/axis_length_fit.sv
// AXI-Stream packet length normaliser: pads short packets with fill beats and
// optionally truncates long ones, behind a single registered output stage.
module axis_length_fit #(
    parameter int DSIZE    = 32,
    parameter int USIZE    = 1,
    parameter int LSIZE    = 16,
    parameter int TRUNCATE = 1
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [DSIZE-1:0]   fill_data,
    input  logic [LSIZE-1:0]   length,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [DSIZE-1:0]   s_axis_tdata,
    input  logic [DSIZE/8-1:0] s_axis_tkeep,
    input  logic [USIZE-1:0]   s_axis_tuser,
    input  logic               s_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [DSIZE-1:0]   m_axis_tdata,
    output logic [DSIZE/8-1:0] m_axis_tkeep,
    output logic [USIZE-1:0]   m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               pkt_padded,
    output logic               pkt_truncated
);
    localparam int KSIZE = DSIZE / 8;
    localparam logic [LSIZE-1:0] ONE_L = {{(LSIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_PASS = 2'b00,
        ST_PAD  = 2'b01,
        ST_DROP = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [LSIZE-1:0]   cnt_r;
    logic [LSIZE-1:0]   len_l_r;
    logic [LSIZE-1:0]   len_eff_s;
    logic [LSIZE-1:0]   len_m1_s;
    logic [LSIZE-1:0]   pad_m1_s;
    logic               m_valid_r;
    logic [DSIZE-1:0]   m_data_r;
    logic [KSIZE-1:0]   m_keep_r;
    logic [USIZE-1:0]   m_user_r;
    logic               m_last_r;
    logic               pad_last_r;
    logic               padded_r;
    logic               truncated_r;
    logic               slot_free_s;
    logic               s_ready_s;
    logic               s_fire_s;
    logic               load_s;
    logic               load_fill_s;
    logic               load_last_s;
    logic               drop_end_s;

    // Next-state, input-ready and output-load decisions
    always_comb begin
        slot_free_s  = !m_valid_r || m_axis_tready;
        // On a packet's first beat the live length applies; afterwards the latched one
        len_eff_s    = (cnt_r == '0) ? length : len_l_r;
        len_m1_s     = len_eff_s - ONE_L;
        pad_m1_s     = len_l_r - ONE_L;
        state_next_s = state_r;
        s_ready_s    = 1'b0;
        load_s       = 1'b0;
        load_fill_s  = 1'b0;
        load_last_s  = 1'b0;
        drop_end_s   = 1'b0;
        case (state_r)
            ST_PASS: begin
                s_ready_s = slot_free_s;
                if (s_axis_tvalid && slot_free_s) begin
                    load_s = 1'b1;
                    if (len_eff_s == '0) begin
                        load_last_s = s_axis_tlast;
                    end else if (s_axis_tlast && (cnt_r < len_m1_s)) begin
                        load_last_s  = 1'b0;
                        state_next_s = ST_PAD;
                    end else if (cnt_r == len_m1_s) begin
                        if (s_axis_tlast) begin
                            load_last_s = 1'b1;
                        end else if (TRUNCATE != 0) begin
                            load_last_s  = 1'b1;
                            state_next_s = ST_DROP;
                        end else begin
                            load_last_s = 1'b0;
                        end
                    end else begin
                        load_last_s = s_axis_tlast;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PAD: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_fill_s = 1'b1;
                    load_last_s = (cnt_r == pad_m1_s);
                    if (load_last_s) begin
                        state_next_s = ST_PASS;
                    end else begin
                        state_next_s = ST_PAD;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_DROP: begin
                // Excess beats are consumed regardless of downstream back-pressure
                s_ready_s = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_end_s   = 1'b1;
                    state_next_s = ST_PASS;
                end else begin
                    drop_end_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_PASS;
            end
        endcase
    end

    assign s_fire_s      = s_axis_tvalid && s_ready_s;
    assign s_axis_tready = s_ready_s && !rst;

    // FSM state register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r <= ST_PASS;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Emitted-beat counter (saturating) and per-packet length latch
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            len_l_r <= '0;
        end else begin
            if ((state_r == ST_PASS) && s_fire_s && (cnt_r == '0)) begin
                len_l_r <= length;
            end
            if (load_s) begin
                if (load_last_s) begin
                    cnt_r <= '0;
                end else if (cnt_r != '1) begin
                    cnt_r <= cnt_r + ONE_L;
                end
            end
        end
    end

    // Output register stage
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            m_valid_r  <= 1'b0;
            m_data_r   <= '0;
            m_keep_r   <= '0;
            m_user_r   <= '0;
            m_last_r   <= 1'b0;
            pad_last_r <= 1'b0;
        end else if (load_s) begin
            m_valid_r  <= 1'b1;
            m_data_r   <= load_fill_s ? fill_data : s_axis_tdata;
            m_keep_r   <= load_fill_s ? {KSIZE{1'b1}} : s_axis_tkeep;
            m_user_r   <= load_fill_s ? {USIZE{1'b0}} : s_axis_tuser;
            m_last_r   <= load_last_s;
            pad_last_r <= load_fill_s && load_last_s;
        end else if (m_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    // Per-packet status pulses
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            padded_r    <= 1'b0;
            truncated_r <= 1'b0;
        end else begin
            padded_r    <= m_valid_r && m_axis_tready && pad_last_r;
            truncated_r <= drop_end_s;
        end
    end

    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = m_data_r;
    assign m_axis_tkeep  = m_keep_r;
    assign m_axis_tuser  = m_user_r;
    assign m_axis_tlast  = m_last_r;
    assign pkt_padded    = padded_r;
    assign pkt_truncated = truncated_r;

endmodule

// File: tb/tb_axis_length_fit.sv
// Bench for axis_length_fit: directed vector table plus random packets, compared
// against a packet-level reference model. dut0 truncates, dut1 does not.
module tb_axis_length_fit;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [0:0]  user;
        logic        last;
    } beat_t;

    typedef struct {
        int d; int n; int len; bit rr; bit span;
        int exp_n; int exp_pad; int exp_tr;
    } vec_t;

    localparam int NV = 12;
    localparam logic [31:0] FILL = 32'hAA55AA55;

    logic        clock = 1'b0;
    logic        rst;
    logic [31:0] fill;
    logic [15:0] len_in [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic [31:0] s_data  [2];
    logic [3:0]  s_keep  [2];
    logic [0:0]  s_user  [2];
    logic        s_last  [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [31:0] m_data  [2];
    logic [3:0]  m_keep  [2];
    logic [0:0]  m_user  [2];
    logic        m_last  [2];
    logic        padded  [2];
    logic        truncd  [2];

    always #5 clock = ~clock;
    assign fill = FILL;

    axis_length_fit #(.DSIZE(32), .USIZE(1), .LSIZE(16), .TRUNCATE(1)) dut0 (
        .clock(clock), .rst(rst), .fill_data(fill), .length(len_in[0]),
        .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
        .s_axis_tkeep(s_keep[0]), .s_axis_tuser(s_user[0]), .s_axis_tlast(s_last[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0]),
        .m_axis_tkeep(m_keep[0]), .m_axis_tuser(m_user[0]), .m_axis_tlast(m_last[0]),
        .pkt_padded(padded[0]), .pkt_truncated(truncd[0]));

    axis_length_fit #(.DSIZE(32), .USIZE(1), .LSIZE(16), .TRUNCATE(0)) dut1 (
        .clock(clock), .rst(rst), .fill_data(fill), .length(len_in[1]),
        .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
        .s_axis_tkeep(s_keep[1]), .s_axis_tuser(s_user[1]), .s_axis_tlast(s_last[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1]),
        .m_axis_tkeep(m_keep[1]), .m_axis_tuser(m_user[1]), .m_axis_tlast(m_last[1]),
        .pkt_padded(padded[1]), .pkt_truncated(truncd[1]));

    int    act = 0;
    bit    rr = 1'b0;
    bit    hung = 1'b0;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    // Monitor state: owned by the negedge process only
    beat_t out_q[$];
    int    out_cyc[$];
    int    pad_cnt = 0;
    int    tr_cnt = 0;
    int    stall_bad = 0;
    bit    held_v = 1'b0;
    beat_t held;
    beat_t mon_s;

    // Scoreboard state: owned by the main process
    beat_t exp_q[$];
    int    exp_pad, exp_tr;
    int    out_base, pad_base, tr_base, stall_base;
    vec_t  vt [NV];

    assign mon_s = {m_data[act], m_keep[act], m_user[act], m_last[act]};

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rst) begin
            held_v <= 1'b0;
        end else begin
            if (held_v && (!m_valid[act] || (mon_s != held))) stall_bad <= stall_bad + 1;
            if (m_valid[act] && m_ready[act]) begin
                out_q.push_back(mon_s);
                out_cyc.push_back(cyc);
            end
            held_v  <= m_valid[act] && !m_ready[act];
            held    <= mon_s;
            pad_cnt <= pad_cnt + int'(padded[act]);
            tr_cnt  <= tr_cnt + int'(truncd[act]);
        end
    end

    initial begin
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            m_ready[0] = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready[1] = rr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Reference: whole-packet rewrite from the length rules
    task automatic model_pkt(input beat_t pk[$], input int len, input bit trunc);
        int    n;
        beat_t f;
        n = pk.size();
        if (len == 0 || n == len || (n > len && !trunc)) begin
            foreach (pk[i]) exp_q.push_back(pk[i]);
        end else if (n < len) begin
            for (int i = 0; i < n; i++) begin
                f = pk[i];
                f.last = 1'b0;
                exp_q.push_back(f);
            end
            for (int i = n; i < len; i++) begin
                f.data = FILL; f.keep = 4'hF; f.user = 1'b0; f.last = (i == len - 1);
                exp_q.push_back(f);
            end
            exp_pad++;
        end else begin
            for (int i = 0; i < len; i++) begin
                f = pk[i];
                f.last = (i == len - 1);
                exp_q.push_back(f);
            end
            exp_tr++;
        end
    endtask

    task automatic send_pkt(input int d, input int n, input int len, input bit gaps);
        beat_t pk[$];
        beat_t b;
        bit    acc;
        int    t;
        if (hung) return;
        len_in[d] = 16'(len);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid[d] = 1'b0;
                @(posedge clock);
                #1;
            end
            b.data = $urandom;
            b.keep = 4'($urandom);
            b.user = 1'($urandom);
            b.last = (i == n - 1);
            s_data[d] = b.data; s_keep[d] = b.keep; s_user[d] = b.user; s_last[d] = b.last;
            s_valid[d] = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clock);
                acc = s_ready[d];
                @(posedge clock);
                #1;
                t++;
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout dut%0d: beat %0d got no tready in %0d cycles, required accept", d, i, t);
                hung = 1'b1;
                s_valid[d] = 1'b0;
                return;
            end
            // Mid-packet length changes must be ignored
            if (i == 0) len_in[d] = 16'($urandom_range(0, 15));
            pk.push_back(b);
        end
        s_valid[d] = 1'b0;
        model_pkt(pk, len, d == 0);
    endtask

    task automatic start_group();
        exp_q.delete();
        exp_pad    = 0;
        exp_tr     = 0;
        out_base   = out_q.size();
        pad_base   = pad_cnt;
        tr_base    = tr_cnt;
        stall_base = stall_bad;
    endtask

    task automatic drain();
        int t = 0;
        while ((out_q.size() - out_base < exp_q.size()) && t < 400) begin
            @(posedge clock);
            t++;
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic check_group(input string name, input int tn, input int tpad, input int ttr, input bit span);
        int got_n = out_q.size() - out_base;
        cmp({name, " beats vs model"}, got_n, exp_q.size());
        if (tn >= 0) cmp({name, " beats vs table"}, got_n, tn);
        for (int i = 0; i < got_n && i < exp_q.size(); i++)
            cmp($sformatf("%s beat%0d {data,keep,user,last}", name, i), out_q[out_base + i], exp_q[i]);
        cmp({name, " pkt_padded count"}, pad_cnt - pad_base, exp_pad);
        cmp({name, " pkt_truncated count"}, tr_cnt - tr_base, exp_tr);
        if (tpad >= 0) cmp({name, " pkt_padded vs table"}, pad_cnt - pad_base, tpad);
        if (ttr >= 0) cmp({name, " pkt_truncated vs table"}, tr_cnt - tr_base, ttr);
        cmp({name, " stall stability violations"}, stall_bad - stall_base, 0);
        if (span && got_n > 0)
            cmp({name, " output cycle span"}, out_cyc[out_cyc.size() - 1] - out_cyc[out_base], got_n - 1);
    endtask

    task automatic chk_zero(input int d, input string name);
        cmp({name, " m_axis_tvalid"}, m_valid[d], 64'd0);
        cmp({name, " m_axis_tdata"}, m_data[d], 64'd0);
        cmp({name, " m_axis_tkeep"}, m_keep[d], 64'd0);
        cmp({name, " m_axis_tuser"}, m_user[d], 64'd0);
        cmp({name, " m_axis_tlast"}, m_last[d], 64'd0);
        cmp({name, " s_axis_tready"}, s_ready[d], 64'd0);
        cmp({name, " pkt_padded"}, padded[d], 64'd0);
        cmp({name, " pkt_truncated"}, truncd[d], 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0; s_data[d] = '0; s_keep[d] = '0;
            s_user[d] = '0; s_last[d] = 1'b0; len_in[d] = '0;
        end
        vt[0]  = '{d:0, n:3, len:8, rr:0, span:1, exp_n:8, exp_pad:1, exp_tr:0};
        vt[1]  = '{d:0, n:7, len:4, rr:0, span:1, exp_n:4, exp_pad:0, exp_tr:1};
        vt[2]  = '{d:1, n:7, len:4, rr:0, span:1, exp_n:7, exp_pad:0, exp_tr:0};
        vt[3]  = '{d:0, n:5, len:0, rr:0, span:1, exp_n:5, exp_pad:0, exp_tr:0};
        vt[4]  = '{d:0, n:5, len:5, rr:0, span:1, exp_n:5, exp_pad:0, exp_tr:0};
        vt[5]  = '{d:0, n:3, len:8, rr:1, span:0, exp_n:8, exp_pad:1, exp_tr:0};
        vt[6]  = '{d:0, n:1, len:1, rr:0, span:1, exp_n:1, exp_pad:0, exp_tr:0};
        vt[7]  = '{d:0, n:3, len:1, rr:0, span:1, exp_n:1, exp_pad:0, exp_tr:1};
        vt[8]  = '{d:0, n:4, len:3, rr:1, span:0, exp_n:3, exp_pad:0, exp_tr:1};
        vt[9]  = '{d:1, n:2, len:5, rr:0, span:1, exp_n:5, exp_pad:1, exp_tr:0};
        vt[10] = '{d:1, n:1, len:0, rr:0, span:1, exp_n:1, exp_pad:0, exp_tr:0};
        vt[11] = '{d:0, n:1, len:3, rr:1, span:0, exp_n:3, exp_pad:1, exp_tr:0};

        repeat (3) @(posedge clock);
        #1;
        chk_zero(0, "reset dut0");
        chk_zero(1, "reset dut1");
        rst = 1'b0;
        @(posedge clock);
        #1;

        for (int k = 0; k < NV; k++) begin
            act = vt[k].d;
            rr  = vt[k].rr;
            @(posedge clock);
            #2;
            start_group();
            send_pkt(vt[k].d, vt[k].n, vt[k].len, 1'b0);
            drain();
            check_group($sformatf("vec%0d", k), vt[k].exp_n, vt[k].exp_pad, vt[k].exp_tr, vt[k].span);
        end

        // Back-to-back exact and bypass packets: no bubble across the boundary
        act = 0;
        rr  = 1'b0;
        @(posedge clock);
        #2;
        start_group();
        send_pkt(0, 5, 5, 1'b0);
        send_pkt(0, 5, 0, 1'b0);
        drain();
        check_group("b2b", 10, 0, 0, 1'b1);

        // Reset while padding, then a fresh short packet
        start_group();
        send_pkt(0, 2, 8, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b1;
        #1;
        chk_zero(0, "reset in PAD");
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        @(posedge clock);
        #1;
        start_group();
        send_pkt(0, 2, 3, 1'b0);
        drain();
        check_group("after reset", 3, 1, 0, 1'b1);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                act = d;
                rr  = 1'($urandom_range(0, 1));
                @(posedge clock);
                #2;
                start_group();
                send_pkt(d, $urandom_range(1, 10), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
                drain();
                check_group($sformatf("rand_d%0d_%0d", d, k), -1, -1, -1, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
